// File: rtl/lb2axil_master_if.sv
// AXI-Lite link between the Local Bus bridge (master) and a downstream register block (slave).
// Latency: wires only, no storage.
// Backpressure: plain AXI-Lite valid/ready on every channel.
//
// Signals keep their axil_ names so they trace directly to the downstream port list.
interface lb2axil_master_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
);
    logic [ADDR_W-1:0] axil_awaddr;
    logic [2:0]        axil_awprot;
    logic              axil_awvalid;
    logic              axil_awready;
    logic [DATA_W-1:0] axil_wdata;
    logic [STRB_W-1:0] axil_wstrb;
    logic              axil_wvalid;
    logic              axil_wready;
    logic [1:0]        axil_bresp;
    logic              axil_bvalid;
    logic              axil_bready;
    logic [ADDR_W-1:0] axil_araddr;
    logic [2:0]        axil_arprot;
    logic              axil_arvalid;
    logic              axil_arready;
    logic [DATA_W-1:0] axil_rdata;
    logic [1:0]        axil_rresp;
    logic              axil_rvalid;
    logic              axil_rready;

    modport master (
        output axil_awaddr, axil_awprot, axil_awvalid,
        output axil_wdata, axil_wstrb, axil_wvalid,
        output axil_bready,
        output axil_araddr, axil_arprot, axil_arvalid,
        output axil_rready,
        input  axil_awready, axil_wready, axil_bresp, axil_bvalid,
        input  axil_arready, axil_rdata, axil_rresp, axil_rvalid
    );

    modport slave (
        input  axil_awaddr, axil_awprot, axil_awvalid,
        input  axil_wdata, axil_wstrb, axil_wvalid,
        input  axil_bready,
        input  axil_araddr, axil_arprot, axil_arvalid,
        input  axil_rready,
        output axil_awready, axil_wready, axil_bresp, axil_bvalid,
        output axil_arready, axil_rdata, axil_rresp, axil_rvalid
    );
endinterface

// File: rtl/lb2axil_master.sv
// Local Bus to AXI-Lite master bridge: one outstanding write and one outstanding read, independent.
// Latency: request sampled at edge 0 -> wready/rvalid pulse in cycle 3 with a zero-wait slave.
// Backpressure: AXI readies stall the FSMs; Local Bus requests are held until the completion pulse.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   waddr/wdata/wstrb/wen      Local Bus write request, wready/werr completion pulse
//   raddr/ren                  Local Bus read request, rdata/rvalid/rerr completion pulse
//   axil                       AXI-Lite master side (lb2axil_master_if.master)
module lb2axil_master #(
    parameter int          ADDR_W   = 12,
    parameter int          DATA_W   = 32,
    parameter int          STRB_W   = DATA_W / 8,
    parameter logic [2:0]  AXI_PROT = 3'b000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [STRB_W-1:0]   wstrb,
    input  logic                wen,
    output logic                wready,
    output logic                werr,
    input  logic [ADDR_W-1:0]   raddr,
    input  logic                ren,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                rerr,
    lb2axil_master_if.master    axil
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;

    // ---------------- write path state ----------------
    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              wready_q, wready_d;
    logic              werr_q, werr_d;

    // ---------------- read path state ----------------
    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              rvalid_q, rvalid_d;
    logic              rerr_q, rerr_d;

    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdat_d    = wdat_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        wready_d  = wready_q;
        werr_d    = werr_q;
        case (w_state_q)
            W_IDLE: begin
                if (wen) begin
                    awaddr_d  = waddr;
                    wdat_d    = wdata;
                    wstrb_d   = wstrb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W retire independently; a channel already done has its valid at 0.
                if (awvalid_q && axil.axil_awready) awvalid_d = 1'b0;
                if (wvalid_q && axil.axil_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d  = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axil.axil_bvalid && bready_q) begin
                    bready_d  = 1'b0;
                    werr_d    = axil.axil_bresp[1];
                    wready_d  = 1'b1;
                    w_state_d = W_DONE;
                end
            end
            W_DONE: begin
                // Request still asserted here belongs to the finished write; ignore it.
                wready_d  = 1'b0;
                werr_d    = 1'b0;
                w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdat_q    <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            wready_q  <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdat_q    <= wdat_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            wready_q  <= wready_d;
            werr_q    <= werr_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rdat_d    = rdat_q;
        rvalid_d  = rvalid_q;
        rerr_d    = rerr_q;
        case (r_state_q)
            R_IDLE: begin
                if (ren) begin
                    araddr_d  = raddr;
                    arvalid_d = 1'b1;
                    r_state_d = R_ADDR;
                end
            end
            R_ADDR: begin
                if (arvalid_q && axil.axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (axil.axil_rvalid && rready_q) begin
                    rready_d  = 1'b0;
                    rdat_d    = axil.axil_rdata;
                    rerr_d    = axil.axil_rresp[1];
                    rvalid_d  = 1'b1;
                    r_state_d = R_DONE;
                end
            end
            R_DONE: begin
                // rdata is left alone so the initiator can sample it late.
                rvalid_d  = 1'b0;
                rerr_d    = 1'b0;
                r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rdat_q    <= '0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rdat_q    <= rdat_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
        end
    end

    assign wready = wready_q;
    assign werr   = werr_q;
    assign rdata  = rdat_q;
    assign rvalid = rvalid_q;
    assign rerr   = rerr_q;

    assign axil.axil_awaddr  = awaddr_q;
    assign axil.axil_awprot  = AXI_PROT;
    assign axil.axil_awvalid = awvalid_q;
    assign axil.axil_wdata   = wdat_q;
    assign axil.axil_wstrb   = wstrb_q;
    assign axil.axil_wvalid  = wvalid_q;
    assign axil.axil_bready  = bready_q;
    assign axil.axil_araddr  = araddr_q;
    assign axil.axil_arprot  = AXI_PROT;
    assign axil.axil_arvalid = arvalid_q;
    assign axil.axil_rready  = rready_q;

endmodule

// File: tb/tb_lb2axil_master.sv
// Bench for lb2axil_master: memory-backed AXI-Lite slave with programmable stalls,
// a protocol monitor, a vector table and hand-written multi-cycle sequences.
module tb_lb2axil_master;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] waddr, raddr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wen, ren;
    logic          wready, werr, rvalid, rerr;
    logic [DW-1:0] rdata;

    always #5 clk = ~clk;

    lb2axil_master_if #(.ADDR_W(AW), .DATA_W(DW)) axil ();

    lb2axil_master #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .AXI_PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wen(wen),
        .wready(wready), .werr(werr),
        .raddr(raddr), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .rerr(rerr),
        .axil(axil)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- slave configuration ----------------
    int         aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit         rand_bp = 1'b0;

    logic [31:0] mem [0:1023];
    int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0, r_hs_cnt = 0;
    int last_aw_vcyc = 0, last_w_vcyc = 0, last_ar_vcyc = 0;

    // Slave: decisions on the falling edge from stable signals, driven #1 after the rising edge.
    initial begin
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, aw_vcyc, w_vcyc, ar_vcyc;
        bit aw_got, w_got, b_pend, r_pend;
        logic [11:0] aw_a, r_a;
        logic [31:0] w_d;
        logic [3:0]  w_s;
        logic n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
        logic [1:0]  n_bresp, n_rresp;
        logic [31:0] n_rdata;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[12'h100 >> 2] = 32'hCAFE0001;
        mem[12'h008 >> 2] = 32'h55AA1234;
        axil.axil_awready = 0; axil.axil_wready = 0; axil.axil_bvalid = 0; axil.axil_bresp = 0;
        axil.axil_arready = 0; axil.axil_rvalid = 0; axil.axil_rdata = 0; axil.axil_rresp = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        aw_a = 0; r_a = 0; w_d = 0; w_s = 0;
        forever begin
            @(negedge clk);
            n_awready = 0; n_wready = 0; n_bvalid = 0; n_arready = 0; n_rvalid = 0;
            n_bresp = 0; n_rresp = 0; n_rdata = 0;
            if (rst) begin
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_vcyc = 0; w_vcyc = 0; ar_vcyc = 0;
            end else begin
                if (axil.axil_awvalid && axil.axil_awready) begin
                    aw_got = 1; aw_a = axil.axil_awaddr; aw_hs_cnt++;
                    last_aw_vcyc = aw_vcyc + 1; aw_vcyc = 0; aw_cnt = 0;
                end else if (axil.axil_awvalid) begin
                    aw_vcyc++; aw_cnt++;
                end
                if (axil.axil_wvalid && axil.axil_wready) begin
                    w_got = 1; w_d = axil.axil_wdata; w_s = axil.axil_wstrb; w_hs_cnt++;
                    last_w_vcyc = w_vcyc + 1; w_vcyc = 0; w_cnt = 0;
                end else if (axil.axil_wvalid) begin
                    w_vcyc++; w_cnt++;
                end
                n_bvalid = axil.axil_bvalid; n_bresp = axil.axil_bresp;
                if (axil.axil_bvalid && axil.axil_bready) begin
                    b_hs_cnt++; n_bvalid = 0;
                end
                if (aw_got && w_got) begin
                    // An error response leaves the target untouched.
                    if (!bresp_cfg[1])
                        for (int i = 0; i < 4; i++)
                            if (w_s[i]) mem[aw_a[11:2]][8*i +: 8] = w_d[8*i +: 8];
                    aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0;
                end else if (b_pend) b_cnt++;
                if (b_pend && !n_bvalid && (rand_bp ? ($urandom_range(0, 1) == 1) : (b_cnt >= b_lat))) begin
                    n_bvalid = 1; n_bresp = bresp_cfg; b_pend = 0;
                end
                if (axil.axil_arvalid && axil.axil_arready) begin
                    r_pend = 1; r_a = axil.axil_araddr; r_cnt = 0; ar_hs_cnt++;
                    last_ar_vcyc = ar_vcyc + 1; ar_vcyc = 0; ar_cnt = 0;
                end else begin
                    if (axil.axil_arvalid) begin ar_vcyc++; ar_cnt++; end
                    if (r_pend) r_cnt++;
                end
                n_rvalid = axil.axil_rvalid; n_rdata = axil.axil_rdata; n_rresp = axil.axil_rresp;
                if (axil.axil_rvalid && axil.axil_rready) begin
                    r_hs_cnt++; n_rvalid = 0;
                end
                if (r_pend && !n_rvalid && (rand_bp ? ($urandom_range(0, 1) == 1) : (r_cnt >= r_lat))) begin
                    n_rvalid = 1; n_rdata = mem[r_a[11:2]]; n_rresp = rresp_cfg; r_pend = 0;
                end
                n_awready = rand_bp ? ($urandom_range(0, 1) == 1) : (aw_cnt >= aw_lat);
                n_wready  = rand_bp ? ($urandom_range(0, 1) == 1) : (w_cnt >= w_lat);
                n_arready = rand_bp ? ($urandom_range(0, 1) == 1) : (ar_cnt >= ar_lat);
            end
            @(posedge clk);
            #1;
            axil.axil_awready = n_awready; axil.axil_wready = n_wready;
            axil.axil_bvalid = n_bvalid; axil.axil_bresp = n_bresp;
            axil.axil_arready = n_arready; axil.axil_rvalid = n_rvalid;
            axil.axil_rdata = n_rdata; axil.axil_rresp = n_rresp;
        end
    end

    // Protocol monitor: valids held until handshake, payload stable, readies in the right phase.
    int viol = 0;
    initial begin
        bit pv_aw, pv_w, pv_ar;
        logic [11:0] p_awaddr, p_araddr;
        logic [31:0] p_wdata;
        logic [3:0]  p_wstrb;
        pv_aw = 0; pv_w = 0; pv_ar = 0; p_awaddr = 0; p_araddr = 0; p_wdata = 0; p_wstrb = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv_aw = 0; pv_w = 0; pv_ar = 0;
            end else begin
                if (pv_aw && (!axil.axil_awvalid || axil.axil_awaddr !== p_awaddr)) viol++;
                if (pv_w && (!axil.axil_wvalid || axil.axil_wdata !== p_wdata || axil.axil_wstrb !== p_wstrb)) viol++;
                if (pv_ar && (!axil.axil_arvalid || axil.axil_araddr !== p_araddr)) viol++;
                if (axil.axil_bready && (axil.axil_awvalid || axil.axil_wvalid)) viol++;
                if (axil.axil_rready && axil.axil_arvalid) viol++;
                if (axil.axil_awprot !== 3'b000 || axil.axil_arprot !== 3'b000) viol++;
                pv_aw = axil.axil_awvalid && !axil.axil_awready;
                pv_w  = axil.axil_wvalid && !axil.axil_wready;
                pv_ar = axil.axil_arvalid && !axil.axil_arready;
                p_awaddr = axil.axil_awaddr; p_araddr = axil.axil_araddr;
                p_wdata = axil.axil_wdata; p_wstrb = axil.axil_wstrb;
            end
        end
    end

    function automatic logic [127:0] outs_all();
        return {wready, werr, rvalid, rerr, rdata,
                axil.axil_awvalid, axil.axil_wvalid, axil.axil_bready, axil.axil_arvalid, axil.axil_rready,
                axil.axil_awaddr, axil.axil_wdata, axil.axil_wstrb, axil.axil_araddr};
    endfunction

    task automatic lb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic err, output int lat);
        bit done;
        @(posedge clk); #1;
        waddr = a; wdata = d; wstrb = s; wen = 1'b1;
        lat = 0; done = 0; err = 1'bx;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (wready) begin err = werr; done = 1; end
            else lat++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL wr_timeout: no wready for addr 0x%0h within 300 cycles", a);
        end
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic lb_read(input logic [11:0] a, output logic [31:0] d, output logic err, output int lat);
        bit done;
        @(posedge clk); #1;
        raddr = a; ren = 1'b1;
        lat = 0; done = 0; err = 1'bx; d = 'x;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (rvalid) begin err = rerr; d = rdata; done = 1; end
            else lat++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL rd_timeout: no rvalid for addr 0x%0h within 300 cycles", a);
        end
        @(posedge clk); #1;
        ren = 1'b0;
    endtask

    // Writes: la/lb/lc = AW/W/B stall cycles. Reads: la = AR stall, lc = R stall.
    typedef struct {
        bit          is_wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          la;
        int          lb;
        int          lc;
        logic [1:0]  resp;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vt [9];

    initial begin
        logic        e1, e2;
        logic [31:0] d2;
        int          l1, l2, n_wr, n_rd, bw, bi;
        logic [31:0] sb [0:63];
        logic [11:0] a;
        logic [31:0] d;
        logic [3:0]  s;

        vt[0] = '{1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 1'b0, 32'h0, 3};
        vt[1] = '{1, 12'h020, 32'h12345678, 4'hF, 4, 0, 0, 2'b00, 1'b0, 32'h0, 7};
        vt[2] = '{1, 12'h024, 32'hAABBCCDD, 4'b0101, 1, 3, 2, 2'b01, 1'b0, 32'h0, 8};
        vt[3] = '{0, 12'h010, 32'h0, 4'h0, 0, 0, 0, 2'b00, 1'b0, 32'hDEADBEEF, 3};
        vt[4] = '{0, 12'h024, 32'h0, 4'h0, 2, 0, 1, 2'b00, 1'b0, 32'h00BB00DD, 6};
        vt[5] = '{1, 12'h030, 32'h0BADF00D, 4'hF, 0, 2, 1, 2'b10, 1'b1, 32'h0, 6};
        vt[6] = '{0, 12'h100, 32'h0, 4'h0, 3, 0, 0, 2'b10, 1'b1, 32'hCAFE0001, 6};
        vt[7] = '{0, 12'h020, 32'h0, 4'h0, 0, 0, 3, 2'b11, 1'b1, 32'h12345678, 6};
        vt[8] = '{0, 12'h030, 32'h0, 4'h0, 1, 0, 0, 2'b00, 1'b0, 32'h00000000, 4};

        rst = 1'b1; wen = 0; ren = 0; waddr = 0; wdata = 0; wstrb = 0; raddr = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", outs_all(), 128'h0);

        // ---------------- vector table ----------------
        n_wr = 0; n_rd = 0;
        for (int i = 0; i < 9; i++) begin
            rand_bp = 0;
            if (vt[i].is_wr) begin
                aw_lat = vt[i].la; w_lat = vt[i].lb; b_lat = vt[i].lc; bresp_cfg = vt[i].resp;
                lb_write(vt[i].addr, vt[i].data, vt[i].strb, e1, l1);
                n_wr++;
                check($sformatf("v%0d_werr", i), e1, vt[i].exp_err);
                check($sformatf("v%0d_wlat", i), l1, vt[i].exp_lat);
                check($sformatf("v%0d_awvalid_cycles", i), last_aw_vcyc, vt[i].la + 1);
                check($sformatf("v%0d_wvalid_cycles", i), last_w_vcyc, vt[i].lb + 1);
            end else begin
                ar_lat = vt[i].la; r_lat = vt[i].lc; rresp_cfg = vt[i].resp;
                lb_read(vt[i].addr, d2, e2, l2);
                n_rd++;
                check($sformatf("v%0d_rerr", i), e2, vt[i].exp_err);
                check($sformatf("v%0d_rdata", i), d2, vt[i].exp_rdata);
                check($sformatf("v%0d_rlat", i), l2, vt[i].exp_lat);
                check($sformatf("v%0d_arvalid_cycles", i), last_ar_vcyc, vt[i].la + 1);
            end
        end
        repeat (2) @(negedge clk);
        check("aw_handshakes", aw_hs_cnt, n_wr);
        check("w_handshakes", w_hs_cnt, n_wr);
        check("b_handshakes", b_hs_cnt, n_wr);
        check("ar_handshakes", ar_hs_cnt, n_rd);
        check("r_handshakes", r_hs_cnt, n_rd);
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;

        // ---------------- concurrent write + read under random backpressure ----------------
        rand_bp = 1; bresp_cfg = 2'b11;
        fork
            lb_write(12'h004, 32'h13579BDF, 4'hF, e1, l1);
            lb_read(12'h008, d2, e2, l2);
        join
        check("conc_werr", e1, 1'b1);
        check("conc_rerr", e2, 1'b0);
        check("conc_rdata", d2, 32'h55AA1234);
        bresp_cfg = 2'b00; rand_bp = 0;
        repeat (3) @(negedge clk);

        // ---------------- back-to-back writes, wen held across wready ----------------
        bw = aw_hs_cnt;
        @(posedge clk); #1;
        waddr = 12'h040; wdata = 32'h11111111; wstrb = 4'hF; wen = 1'b1;
        bi = 0;
        while (!wready && bi < 50) begin @(negedge clk); bi++; end
        check("b2b_first_wready", wready, 1'b1);
        @(posedge clk); #1;
        waddr = 12'h044; wdata = 32'h22222222;
        @(negedge clk);
        check("b2b_gap_awvalid", axil.axil_awvalid, 1'b0);
        @(negedge clk);
        check("b2b_second_awvalid", axil.axil_awvalid, 1'b1);
        check("b2b_second_awaddr", axil.axil_awaddr, 12'h044);
        bi = 0;
        while (!wready && bi < 50) begin @(negedge clk); bi++; end
        check("b2b_second_wready", wready, 1'b1);
        @(posedge clk); #1;
        wen = 1'b0;
        repeat (4) @(negedge clk);
        check("b2b_aw_count", aw_hs_cnt - bw, 2);
        check("b2b_mem_first", mem[12'h040 >> 2], 32'h11111111);
        check("b2b_mem_second", mem[12'h044 >> 2], 32'h22222222);

        // ---------------- random write/read pairs against a scoreboard ----------------
        rand_bp = 1;
        for (int i = 0; i < 64; i++) sb[i] = 32'h0;
        for (int i = 0; i < 100; i++) begin
            bi = $urandom_range(0, 63);
            a = 12'h200 + 12'(bi * 4);
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            lb_write(a, d, s, e1, l1);
            for (int k = 0; k < 4; k++) if (s[k]) sb[bi][8*k +: 8] = d[8*k +: 8];
            bi = $urandom_range(0, 63);
            a = 12'h200 + 12'(bi * 4);
            lb_read(a, d2, e2, l2);
            check($sformatf("rand_rd%0d_addr%0h", i, a), d2, sb[bi]);
        end
        rand_bp = 0;
        repeat (3) @(negedge clk);

        // ---------------- reset mid-transaction ----------------
        aw_lat = 50; w_lat = 0; r_lat = 50; ar_lat = 0;
        @(posedge clk); #1;
        waddr = 12'h050; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wen = 1'b1;
        raddr = 12'h010; ren = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_rst_awvalid", axil.axil_awvalid, 1'b1);
        check("pre_rst_rready", axil.axil_rready, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1; wen = 1'b0; ren = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        aw_lat = 0; r_lat = 0;
        @(negedge clk);
        check("post_rst_outputs", outs_all(), 128'h0);
        lb_write(12'h060, 32'h600DF00D, 4'hF, e1, l1);
        check("post_rst_werr", e1, 1'b0);
        check("post_rst_wlat", l1, 3);
        lb_read(12'h060, d2, e2, l2);
        check("post_rst_rdata", d2, 32'h600DF00D);
        check("post_rst_rlat", l2, 3);

        repeat (3) @(negedge clk);
        check("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lb2axil_master.md
Name: lb2axil_master

Overview:
- Local Bus to AXI-Lite master bridge; the opposite direction of our AXI-Lite-to-Local-Bus slave bridge.
- Accepts Local Bus write and read requests from an internal initiator (DMA/sequencer) and issues single AXI-Lite master transactions to a downstream register block or interconnect.
- Write and read paths are independent FSMs and may be in flight concurrently; one outstanding transaction per direction.
- Reports AXI response errors back onto the Local Bus.

Parameters:
ADDR_W, 12, address width on both buses
DATA_W, 32, data width on both buses
STRB_W, DATA_W/8, byte-strobe width
AXI_PROT, 3'b000, constant driven on axil_awprot/axil_arprot

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
waddr  input  ADDR_W  Local Bus write address
wdata  input  DATA_W  Local Bus write data
wstrb  input  STRB_W  Local Bus write strobes
wen  input  1  write request; held with waddr/wdata/wstrb stable until wready
wready  output  1  one-cycle write-complete pulse
werr  output  1  valid with wready; 1 = bresp was SLVERR/DECERR
raddr  input  ADDR_W  Local Bus read address
ren  input  1  read request; held with raddr stable until rvalid
rdata  output  DATA_W  read data, valid with rvalid
rvalid  output  1  one-cycle read-complete pulse
rerr  output  1  valid with rvalid; 1 = rresp was SLVERR/DECERR
axil_awaddr  output  ADDR_W  AXI write address
axil_awprot  output  3  = AXI_PROT
axil_awvalid  output  1  AXI write address valid
axil_awready  input  1  AXI write address ready
axil_wdata  output  DATA_W  AXI write data
axil_wstrb  output  STRB_W  AXI write strobes
axil_wvalid  output  1  AXI write data valid
axil_wready  input  1  AXI write data ready
axil_bresp  input  2  AXI write response
axil_bvalid  input  1  AXI write response valid
axil_bready  output  1  AXI write response ready
axil_araddr  output  ADDR_W  AXI read address
axil_arprot  output  3  = AXI_PROT
axil_arvalid  output  1  AXI read address valid
axil_arready  input  1  AXI read address ready
axil_rdata  input  DATA_W  AXI read data
axil_rresp  input  2  AXI read response
axil_rvalid  input  1  AXI read data valid
axil_rready  output  1  AXI read data ready

Behaviour:
- Reset: all registered outputs 0 (awvalid, wvalid, bready, arvalid, rready, wready, werr, rvalid, rerr, addr/data/strb registers); both FSMs go to IDLE. A reset mid-transaction abandons it; the downstream slave shares rst.
- Write FSM, states W_IDLE, W_REQ, W_RESP, W_DONE:
  - W_IDLE: on wen=1, latch waddr/wdata/wstrb into axil_awaddr/axil_wdata/axil_wstrb, set awvalid=1 and wvalid=1, go to W_REQ.
  - W_REQ: awvalid drops the cycle after awvalid&&awready; wvalid drops the cycle after wvalid&&wready. The two handshakes are tracked independently and may occur in either order or the same cycle. After both complete, set bready=1 and go to W_RESP. bready is never 1 outside W_RESP.
  - W_RESP: on bvalid&&bready, clear bready, register werr=bresp[1], pulse wready=1 for one cycle, go to W_DONE.
  - W_DONE: drop wready and werr, return to W_IDLE. wen in W_DONE is ignored; the next request is sampled in W_IDLE.
- Minimum write latency: wen sampled at edge 0; AW/W handshakes in cycle 1; bvalid in cycle 2; wready high in cycle 3.
- AXI valid signals never drop before their handshake. Latched AXI payload is stable while valid is high.
- Read FSM, states R_IDLE, R_ADDR, R_DATA, R_DONE:
  - R_IDLE: on ren=1, latch raddr, set arvalid=1, go to R_ADDR.
  - R_ADDR: on arvalid&&arready, clear arvalid, set rready=1, go to R_DATA.
  - R_DATA: on axil_rvalid&&rready, clear rready, register rdata=axil_rdata and rerr=rresp[1], pulse rvalid=1, go to R_DONE.
  - R_DONE: drop rvalid and rerr, return to R_IDLE. rdata holds its value until the next read completes.
- Minimum read latency: ren sampled at edge 0; rvalid high in cycle 3.
- Initiator rule: after wready/rvalid, the initiator drops or changes its request on the next edge. The bridge does not re-issue a request while in W_DONE/R_DONE.
- Write and read FSMs share no state; simultaneous wen and ren each start in the same cycle.
- OKAY and EXOKAY both give err=0.

Test Plan:
- Single write, slave always ready: waddr=0x010, wdata=0xDEADBEEF, wstrb=0xF -> awaddr=0x010 and wdata=0xDEADBEEF with awvalid/wvalid in cycle 1; wready pulse in cycle 3; werr=0; exactly one AW and one W handshake.
- Write with skewed readies: awready delayed 4 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 5 cycles, bready only after both handshakes; wready pulses once; payload stable throughout.
- Read with rresp=2'b10, rdata=0xCAFE0001 after 3-cycle arready stall -> rvalid pulse with rdata=0xCAFE0001, rerr=1; rready high only in R_DATA.
- Concurrent wen (0x004) and ren (0x008) in the same cycle, slave with random backpressure -> both complete independently with correct data; bresp=2'b11 -> werr=1.
- Back-to-back writes with wen held high across wready -> second AW issued 1 cycle after W_DONE, no duplicate transaction; 100 random write/read pairs match a scoreboard.
- rst asserted while in W_REQ and R_DATA -> next cycle all AXI valid/ready and Local Bus outputs are 0 and both FSMs are in IDLE; a new write after reset completes normally.
